// File: rtl/ps2_frame_rx_if.sv
// Frame hand-off between the PS/2 receiver and the downstream 11-bit frame queue.
interface ps2_frame_rx_if;
  logic [10:0] frame;
  logic        enqueue;
  logic        full;

  modport master (output frame, output enqueue, input full);
  modport slave  (input frame, input enqueue, output full);
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver feeding an 11-bit frame queue.
// Define PS2_FRAME_CHECK_EN to reject frames with a bad start, stop or odd-parity bit.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_frame_rx_if.master        q,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overflow,
  output logic [7:0]            drop_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic [10:0]            shift_q;
  logic [10:0]            shift_d;
  logic [3:0]             bit_cnt_q;
  logic [TW-1:0]          tmo_q;
  logic [10:0]            frame_q;
  logic                   enqueue_q;
  logic                   busy_q;
  logic                   frame_err_q;
  logic                   overflow_q;
  logic [7:0]             drop_q;
  logic                   fall_s;
  logic                   data_s;

`ifdef PS2_FRAME_CHECK_EN
  function automatic logic frame_valid(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && (^f[9:1] == 1'b1);
  endfunction
`endif

  assign fall_s  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];
  assign shift_d = {data_s, shift_q[10:1]};

  // Synchronizers idle high like the open-collector PS/2 lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  // Receive FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= 11'd0;
      bit_cnt_q   <= 4'd0;
      tmo_q       <= '0;
      frame_q     <= 11'd0;
      enqueue_q   <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      enqueue_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tmo_q <= '0;
          if (fall_s && !data_s) begin
            shift_q   <= {1'b0, 10'd0};
            bit_cnt_q <= 4'd1;
            state_q   <= ST_SHIFT;
            busy_q    <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (fall_s) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 4'd1;
            tmo_q     <= '0;
            if (bit_cnt_q == 4'd10) begin
              state_q <= ST_PUSH;
            end else begin
              state_q <= ST_SHIFT;
            end
          end else if (tmo_q == TMO_LAST) begin
            frame_err_q <= 1'b1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_PUSH: begin
          // Any PS/2 edge seen in this single cycle is deliberately ignored.
          frame_q <= shift_q;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`ifdef PS2_FRAME_CHECK_EN
          if (!frame_valid(shift_q)) begin
            frame_err_q <= 1'b1;
          end else
`endif
          if (q.full) begin
            overflow_q <= 1'b1;
            if (drop_q != 8'hFF) begin
              drop_q <= drop_q + 8'd1;
            end
          end else begin
            enqueue_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign q.frame     = frame_q;
  assign q.enqueue   = enqueue_q;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed self-checking bench for ps2_frame_rx (short timeout for fast runs).
module tb_ps2_frame_rx;

  localparam int T = 64;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       busy;
  logic       frame_err;
  logic       overflow;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int enq_tot = 0;
  int err_tot = 0;
  int ovf_tot = 0;
  logic [10:0] last_frame = 11'd0;

  ps2_frame_rx_if qif ();

  ps2_frame_rx #(.TIMEOUT_CYCLES(T), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .q          (qif),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (qif.enqueue) begin
      enq_tot    <= enq_tot + 1;
      last_frame <= qif.frame;
    end
    if (frame_err) err_tot <= err_tot + 1;
    if (overflow)  ovf_tot <= ovf_tot + 1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(10);
    ps2_clk = 1'b1;
    cyc(5);
  endtask

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    cyc(5);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(4);
    checks++; if (qif.frame !== 11'd0)   begin errors++; $display("FAIL reset_frame got %h want 000", qif.frame); end
    checks++; if (qif.enqueue !== 1'b0)  begin errors++; $display("FAIL reset_enqueue got %b want 0", qif.enqueue); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_err !== 1'b0)    begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (drop_count !== 8'd0)   begin errors++; $display("FAIL reset_drop_count got %0d want 0", drop_count); end
    reset = 1'b0;
    cyc(4);
  endtask

  // 0x1C: start 0, data LSB first, parity 0, stop 1 -> frame 0x438.
  task automatic test_scancode();
    logic [10:0] f;
    int e0, er0, n;
    logic seen;
    logic [10:0] fr;
    f = 11'h438;
    e0 = enq_tot; er0 = err_tot; seen = 1'b0; fr = 11'd0; n = 0;
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = 1'b1;
    cyc(5);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (qif.enqueue && !seen) begin seen = 1'b1; n = k; fr = qif.frame; end
    end
    ps2_clk = 1'b1;
    cyc(10);
    checks++; if (!seen || n != S + 2) begin errors++; $display("FAIL scancode_latency got %0d want %0d", n, S + 2); end
    checks++; if (fr !== 11'h438)      begin errors++; $display("FAIL scancode_frame got %h want 438", fr); end
    checks++; if (enq_tot - e0 != 1)   begin errors++; $display("FAIL scancode_enq_count got %0d want 1", enq_tot - e0); end
    checks++; if (err_tot - er0 != 0)  begin errors++; $display("FAIL scancode_err_count got %0d want 0", err_tot - er0); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL scancode_busy got %b want 0", busy); end
  endtask

  task automatic test_bad_parity();
    int e0, er0;
    e0 = enq_tot; er0 = err_tot;
    send_frame(11'h638);
`ifdef PS2_FRAME_CHECK_EN
    checks++; if (err_tot - er0 != 1) begin errors++; $display("FAIL badpar_err got %0d want 1", err_tot - er0); end
    checks++; if (enq_tot - e0 != 0)  begin errors++; $display("FAIL badpar_enq got %0d want 0", enq_tot - e0); end
`else
    checks++; if (enq_tot - e0 != 1)     begin errors++; $display("FAIL badpar_enq got %0d want 1", enq_tot - e0); end
    checks++; if (last_frame !== 11'h638) begin errors++; $display("FAIL badpar_frame got %h want 638", last_frame); end
`endif
  endtask

  task automatic test_queue_full();
    int e0, o0;
    e0 = enq_tot; o0 = ovf_tot;
    qif.full = 1'b1;
    send_frame(11'h438);
    send_frame(11'h438);
    checks++; if (ovf_tot - o0 != 2)  begin errors++; $display("FAIL full_overflow got %0d want 2", ovf_tot - o0); end
    checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL full_drop_count got %0d want 2", drop_count); end
    checks++; if (enq_tot - e0 != 0)  begin errors++; $display("FAIL full_enq got %0d want 0", enq_tot - e0); end
    qif.full = 1'b0;
    send_frame(11'h438);
    checks++; if (enq_tot - e0 != 1)     begin errors++; $display("FAIL full_release_enq got %0d want 1", enq_tot - e0); end
    checks++; if (last_frame !== 11'h438) begin errors++; $display("FAIL full_release_frame got %h want 438", last_frame); end
  endtask

  // Pulse is T cycles after the edge is seen; the synchronizer plus edge detect add S+1.
  task automatic test_timeout();
    logic [10:0] f;
    int er0, e0, n;
    f = 11'h438;
    er0 = err_tot; e0 = enq_tot; n = 0;
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    ps2_data = f[4];
    cyc(5);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 10) ps2_clk = 1'b1;
      if (frame_err && n == 0) n = k;
    end
    checks++; if (n != S + T + 1)      begin errors++; $display("FAIL timeout_delay got %0d want %0d", n, S + T + 1); end
    checks++; if (err_tot - er0 != 1)  begin errors++; $display("FAIL timeout_err_count got %0d want 1", err_tot - er0); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL timeout_busy got %b want 0", busy); end
    send_frame(11'h438);
    checks++; if (enq_tot - e0 != 1)     begin errors++; $display("FAIL timeout_next_enq got %0d want 1", enq_tot - e0); end
    checks++; if (last_frame !== 11'h438) begin errors++; $display("FAIL timeout_next_frame got %h want 438", last_frame); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    int e0, er0, o0;
    f = 11'h438;
    checks++; if (drop_count === 8'd0) begin errors++; $display("FAIL midrst_precond got %0d want nonzero", drop_count); end
    for (int i = 0; i < 6; i++) send_bit(f[i]);
    e0 = enq_tot; er0 = err_tot; o0 = ovf_tot;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(20);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL midrst_drop_count got %0d want 0", drop_count); end
    checks++; if (qif.frame !== 11'd0) begin errors++; $display("FAIL midrst_frame got %h want 000", qif.frame); end
    checks++; if ((enq_tot - e0) + (err_tot - er0) + (ovf_tot - o0) != 0)
      begin errors++; $display("FAIL midrst_pulses got %0d want 0", (enq_tot - e0) + (err_tot - er0) + (ovf_tot - o0)); end
    send_frame(11'h438);
    checks++; if (enq_tot - e0 != 1)     begin errors++; $display("FAIL midrst_next_enq got %0d want 1", enq_tot - e0); end
    checks++; if (last_frame !== 11'h438) begin errors++; $display("FAIL midrst_next_frame got %h want 438", last_frame); end
  endtask

  // 0x5A has four ones, so odd parity is 1: frame = 0x400|0x200|0x0B4 = 0x6B4.
  task automatic test_glitch_idle();
    int e0, er0;
    logic b;
    e0 = enq_tot; er0 = err_tot;
    ps2_data = 1'b1;
    cyc(5);
    ps2_clk = 1'b0;
    cyc(8);
    b = busy;
    ps2_clk = 1'b1;
    cyc(10);
    checks++; if (b !== 1'b0)         begin errors++; $display("FAIL glitch_busy got %b want 0", b); end
    checks++; if (err_tot - er0 != 0) begin errors++; $display("FAIL glitch_err got %0d want 0", err_tot - er0); end
    send_frame(11'h6B4);
    checks++; if (enq_tot - e0 != 1)     begin errors++; $display("FAIL glitch_next_enq got %0d want 1", enq_tot - e0); end
    checks++; if (last_frame !== 11'h6B4) begin errors++; $display("FAIL glitch_next_frame got %h want 6b4", last_frame); end
  endtask

  initial begin
    qif.full = 1'b0;
    test_reset();
    test_scancode();
    test_bad_parity();
    test_queue_full();
    test_timeout();
    test_reset_mid_frame();
    test_glitch_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

PS/2 device-to-host receiver that deserializes 11-bit PS/2 frames (start, 8 data bits LSB first, odd parity, stop) from the raw `ps2_clk`/`ps2_data` lines. It sits directly upstream of the 11-bit frame `queue`. It drives that queue's `d` and `enqueue` inputs and honours its `full` output. Receiving frames does not depend on the queue being drained; frames that arrive while the queue is full are dropped and counted.

## Interface
- `TIMEOUT_CYCLES`, default 5000: number of `clk` cycles without a PS/2 clock falling edge after which a partial frame is abandoned.
- `SYNC_STAGES`, default 2: flop depth of the input synchronizers. Minimum 2.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-high.
- `ps2_clk` input, 1 bit: raw PS/2 clock line, asynchronous to `clk`.
- `ps2_data` input, 1 bit: raw PS/2 data line, asynchronous to `clk`.
- `full` input, 1 bit: queue full flag.
- `frame` output, 11 bits: received frame. Bit [0] is start, [8:1] is data, [9] is parity, [10] is stop. Drives queue `d`.
- `enqueue` output, 1 bit: one-cycle push strobe to the queue.
- `busy` output, 1 bit: high while a frame is partially received.
- `frame_err` output, 1 bit: one-cycle pulse on timeout or, when enabled, on a framing/parity error.
- `overflow` output, 1 bit: one-cycle pulse when a good frame is dropped because `full` is high.
- `drop_count` output, 8 bits: saturating count of frames dropped due to `full`.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a `SYNC_STAGES`-deep synchronizer.
  - A falling edge is detected when the previous synchronized clock is 1 and the current one is 0.
  - Data is sampled from the synchronized `ps2_data` in the same cycle the falling edge is detected.
- **Deserializer**
  - An 11-bit shift register shifts right, inserting the new bit at [10].
  - After 11 shifts, the first bit received is in [0].
  - A 4-bit bit counter tracks progress.
- **FSM states:**
  - **IDLE**
    - A falling edge with data 0 loads the start bit, sets the bit counter to 1 and moves to SHIFT.
    - A falling edge with data 1 is ignored as a glitch; the FSM stays in IDLE.
  - **SHIFT**
    - Each falling edge shifts in one bit and increments the counter.
    - On the edge that makes the count 11, the FSM moves to PUSH.
    - If the timeout expires first, the FSM pulses `frame_err` and returns to IDLE.
  - **PUSH** (exactly one cycle, then IDLE): the frame is evaluated in priority order.
    1. If the validity check is enabled and the frame is invalid, pulse `frame_err`.
    2. Otherwise, if `full` is 1, pulse `overflow` and increment `drop_count` (saturates at 255).
    3. Otherwise, pulse `enqueue`.
- **Timeout counter**
  - Clears on every falling edge and in IDLE.
  - Increments in SHIFT.
  - Expires when it reaches `TIMEOUT_CYCLES-1`.
- `busy` is 1 in SHIFT and PUSH, and 0 in IDLE.
- `frame` is registered and holds its last pushed or evaluated value until the next PUSH.
- `enqueue` is never asserted while `full` is 1 in the same cycle.

## Timing
- **Reset values:** `frame`=0, `enqueue`=0, `busy`=0, `frame_err`=0, `overflow`=0, `drop_count`=0, FSM in IDLE, synchronizers cleared to 1.
- **Reset mid-frame:** discards the partial frame with no pulses generated.
- **Latency:** from the raw `ps2_clk` falling edge of the stop bit to `enqueue` high is `SYNC_STAGES`+2 cycles.
- `frame` is valid in the same cycle as `enqueue`; the queue captures it on that rising edge.
- `full` is sampled only in the PUSH cycle.
- A falling edge that arrives in the PUSH cycle is ignored. This is legal because PS/2 bit periods are much longer than one `clk` cycle.
- `frame_err` and `overflow` are mutually exclusive, single-cycle pulses.

## Configuration
- **`PS2_FRAME_CHECK_EN` defined:** in PUSH a frame is valid only if start=0, stop=1 and ^`frame[9:1]`=1 (odd parity). Invalid frames pulse `frame_err` and are not enqueued.
- **`PS2_FRAME_CHECK_EN` undefined:** no validity logic exists; every completed 11-bit frame is enqueued (or dropped if `full`). `frame_err` pulses only on timeout.

## Test plan
- **Scancode 0x1C:** send start 0, data 0x1C LSB first, parity 0, stop 1 with `full`=0. Expect one `enqueue` pulse with `frame`=0x438, `SYNC_STAGES`+2 cycles after the stop edge, and `busy` back to 0.
- **Bad parity:** same frame with parity 1.
  - With `PS2_FRAME_CHECK_EN`: expect a `frame_err` pulse and no `enqueue`.
  - Without it: expect `enqueue` with `frame`=0x638.
- **Queue full:** hold `full`=1 and send 0x438 twice. Expect two `overflow` pulses, `drop_count`=2 and no `enqueue`. Then release `full` and send 0x438; expect a normal `enqueue`.
- **Timeout:** send 5 edges, then hold `ps2_clk` high. Expect a `frame_err` pulse `TIMEOUT_CYCLES` cycles after the last edge and `busy`=0. The next full 0x438 frame is enqueued correctly.
- **Reset mid-frame:** assert `reset` after 6 bits with `drop_count` nonzero. Expect all outputs at reset values and no pulses. The following frame is received cleanly.
- **Glitch in IDLE:** a falling edge with `ps2_data`=1 in IDLE leaves `busy`=0, and the next valid frame decodes correctly.
